uc_multiciclo: RTL

Multicycle control unit for the RV64 subset datapath (load, store, add/sub, addi, beq/bne/blt/bge/bltu/bgeu). It takes the opcode and funct3 from the IR output and the branch flag from the ULA. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the PC and IR load enables, register-file and data-memory write enables, and the three datapath mux selects, so the ULA no longer decodes control from the raw instruction word.

---
 rtl/uc_multiciclo_if.sv | 35 +++
 rtl/uc_multiciclo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo_if.sv
// uc_multiciclo_if: bundle between the multicycle control unit and its datapath.
//   Datapath -> control (master drives): opcode, funct3, flag.
//   Control -> datapath (slave drives):  ir_en, pc_en, rf_we, mem_we, alu_src,
//                                        mem_to_reg, pc_src, state, illegal,
//                                        instr_count.
//   The control unit takes the slave modport; the datapath (or a bench) takes master.
interface uc_multiciclo_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             flag;
  logic             ir_en;
  logic             pc_en;
  logic             rf_we;
  logic             mem_we;
  logic             alu_src;
  logic             mem_to_reg;
  logic             pc_src;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output opcode, funct3, flag,
    input  ir_en, pc_en, rf_we, mem_we, alu_src, mem_to_reg, pc_src,
           state, illegal, instr_count
  );

  modport slave (
    input  opcode, funct3, flag,
    output ir_en, pc_en, rf_we, mem_we, alu_src, mem_to_reg, pc_src,
           state, illegal, instr_count
  );
endinterface

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control unit for the RV64 subset datapath
// (load, store, add/sub, addi and the six conditional branches).
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB and drives the datapath
// load enables, write strobes and mux selects.
// Ports:
//   clock    rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      uc_multiciclo_if.slave (instruction fields and flag in,
//            enables/selects/state/illegal/instr_count out)
// Parameters:
//   HALT_ON_ILLEGAL  1: unsupported instruction enters HALT; 0: PC+4 NOP
//   CNT_W            width of the retired-instruction counter
module uc_multiciclo #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input logic            clock,
  input logic            reset_n,
  uc_multiciclo_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic lat_legal, is_load, is_store, is_rtype, is_addi, is_branch;
  logic ir_en, pc_en, rf_we, mem_we, alu_src, mem_to_reg, pc_src;
  logic ir_en_c, pc_en_c, rf_we_c, mem_we_c, alu_src_c, mem_to_reg_c, pc_src_c;

  // funct3 010/011 are unused encodings in the branch opcode space.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ADDI: is_legal = 1'b1;
      OP_BRANCH:                            is_legal = (f3 != 3'b010) && (f3 != 3'b011);
      default:                              is_legal = 1'b0;
    endcase
  endfunction

  // Class decodes come only from the latched copy, so an illegal NOP
  // reaching WB decodes as "no class" and leaves rf_we low.
  assign lat_legal = is_legal(op_q, f3_q);
  assign is_load   = lat_legal && (op_q == OP_LOAD);
  assign is_store  = lat_legal && (op_q == OP_STORE);
  assign is_rtype  = lat_legal && (op_q == OP_RTYPE);
  assign is_addi   = lat_legal && (op_q == OP_ADDI);
  assign is_branch = lat_legal && (op_q == OP_BRANCH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (is_legal(bus.opcode, bus.funct3)) begin
          state_d = EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          state_d = HALT;
        end else begin
          state_d = WB;
        end
      end
      EXEC: begin
        if (is_branch) begin
          state_d = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM:     state_d = is_load ? WB : FETCH;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Every enable/select is gated by reset_n so that asserting reset drops
  // them at once, including the ir_en that FETCH would otherwise raise.
  always_comb begin
    ir_en_c      = 1'b0;
    pc_en_c      = 1'b0;
    rf_we_c      = 1'b0;
    mem_we_c     = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_src_c     = 1'b0;
    case (state_q)
      FETCH: ir_en_c = 1'b1;
      EXEC: begin
        alu_src_c = is_rtype || is_branch;
        if (is_branch) begin
          pc_en_c  = 1'b1;
          pc_src_c = bus.flag;
        end
      end
      MEM: begin
        if (is_store) begin
          mem_we_c = 1'b1;
          pc_en_c  = 1'b1;
        end
      end
      WB: begin
        rf_we_c      = is_load || is_rtype || is_addi;
        mem_to_reg_c = !is_load;
        pc_en_c      = 1'b1;
      end
      default: ;
    endcase
    ir_en      = ir_en_c      && reset_n;
    pc_en      = pc_en_c      && reset_n;
    rf_we      = rf_we_c      && reset_n;
    mem_we     = mem_we_c     && reset_n;
    alu_src    = alu_src_c    && reset_n;
    mem_to_reg = mem_to_reg_c && reset_n;
    pc_src     = pc_src_c     && reset_n;
  end

  // Instruction latch, sticky illegal flag and retire counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
        f3_q <= bus.funct3;
      end
      if (state_d == HALT) begin
        illegal_q <= 1'b1;
      end
      if (pc_en) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.ir_en       = ir_en;
  assign bus.pc_en       = pc_en;
  assign bus.rf_we       = rf_we;
  assign bus.mem_we      = mem_we;
  assign bus.alu_src     = alu_src;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.pc_src      = pc_src;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule
